// File: rtl/occamy_spi_mailbox_pkg.sv
// Shared definitions for the SPI mailbox: register map, STATUS layout, FSM states
// and the AXI-lite payload structs used as default port types.
package occamy_spi_mailbox_pkg;

    localparam int unsigned AXI_AW = 32;
    localparam int unsigned AXI_DW = 32;
    localparam int unsigned AXI_SW = AXI_DW / 8;

    // Register index taken from addr[3:2]
    localparam logic [1:0] REG_H2S_DATA = 2'd0;
    localparam logic [1:0] REG_S2H_DATA = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_SCRATCH  = 2'd3;

    localparam int unsigned STATUS_H2S_EMPTY = 0;
    localparam int unsigned STATUS_H2S_FULL  = 1;
    localparam int unsigned STATUS_S2H_EMPTY = 2;
    localparam int unsigned STATUS_S2H_FULL  = 3;
    localparam int unsigned STATUS_H2S_CNT   = 8;
    localparam int unsigned STATUS_S2H_CNT   = 16;
    localparam int unsigned STATUS_CNT_W     = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    typedef struct packed {
        logic [AXI_AW-1:0] addr;
    } mb_ax_t;

    typedef struct packed {
        logic [AXI_DW-1:0] data;
        logic [AXI_SW-1:0] strb;
    } mb_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } mb_b_t;

    typedef struct packed {
        logic [AXI_DW-1:0] data;
        logic [1:0]        resp;
    } mb_r_t;

    typedef struct packed {
        mb_ax_t aw;
        logic   aw_valid;
        mb_w_t  w;
        logic   w_valid;
        logic   b_ready;
        mb_ax_t ar;
        logic   ar_valid;
        logic   r_ready;
    } mb_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   w_ready;
        mb_b_t  b;
        logic   b_valid;
        logic   ar_ready;
        mb_r_t  r;
        logic   r_valid;
    } mb_rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the fifo_v3 port shape; a push into a full FIFO succeeds
// when a pop happens in the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned CNT_W = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  do_push, do_pop, bypass;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];

    // In fall-through mode a push and pop on an empty FIFO pass straight through
    assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop) && !bypass;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + ADDR_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_DEPTH'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/occamy_spi_mailbox.sv
// AXI-lite mailbox between the SPI slave (host) and the SoC: one FIFO per
// direction, a STATUS register and a scratch register.
module occamy_spi_mailbox
    import occamy_spi_mailbox_pkg::*;
#(
    parameter type         axi_lite_req_t  = mb_req_t,
    parameter type         axi_lite_resp_t = mb_rsp_t,
    parameter int unsigned DEPTH           = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  axi_lite_req_t  axi_lite_req_i,
    output axi_lite_resp_t axi_lite_rsp_o,
    output logic [31:0]    h2s_data_o,
    output logic           h2s_valid_o,
    input  logic           h2s_ready_i,
    input  logic [31:0]    s2h_data_i,
    input  logic           s2h_valid_i,
    output logic           s2h_ready_o
);

    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  h2s_full, h2s_empty, h2s_push, h2s_pop;
    logic                  s2h_full, s2h_empty, s2h_push, s2h_pop;
    logic [ADDR_DEPTH-1:0] h2s_usage, s2h_usage;
    logic [31:0]           s2h_head;
    logic [31:0]           status_c;

    w_state_e    w_state_q, w_state_d;
    logic        aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
    logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d, scratch_q, scratch_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    r_state_e    r_state_q, r_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        aw_ready_c, w_ready_c, ar_ready_c, aw_hs, w_hs, ar_hs;
    logic [31:0] wa, wd, ar_addr;
    logic [3:0]  ws;
    logic        unused_addr_bits;

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(DEPTH)) i_h2s_fifo (
        .clk_i, .rst_ni, .flush_i(1'b0),
        .full_o(h2s_full), .empty_o(h2s_empty), .usage_o(h2s_usage),
        .data_i(wd), .push_i(h2s_push), .data_o(h2s_data_o), .pop_i(h2s_pop)
    );

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(DEPTH)) i_s2h_fifo (
        .clk_i, .rst_ni, .flush_i(1'b0),
        .full_o(s2h_full), .empty_o(s2h_empty), .usage_o(s2h_usage),
        .data_i(s2h_data_i), .push_i(s2h_push), .data_o(s2h_head), .pop_i(s2h_pop)
    );

    assign h2s_valid_o = !h2s_empty;
    assign h2s_pop     = !h2s_empty && h2s_ready_i;
    assign s2h_ready_o = !s2h_full;
    assign s2h_push    = s2h_valid_i && !s2h_full;

    assign aw_ready_c = (w_state_q == W_IDLE) && !aw_cap_q;
    assign w_ready_c  = (w_state_q == W_IDLE) && !w_cap_q;
    assign ar_ready_c = (r_state_q == R_IDLE);
    assign aw_hs      = axi_lite_req_i.aw_valid && aw_ready_c;
    assign w_hs       = axi_lite_req_i.w_valid && w_ready_c;
    assign ar_hs      = axi_lite_req_i.ar_valid && ar_ready_c;

    // Effective write operands: captured copy if already accepted, else live bus
    assign wa      = aw_cap_q ? waddr_q : axi_lite_req_i.aw.addr;
    assign wd      = w_cap_q ? wdata_q : axi_lite_req_i.w.data;
    assign ws      = w_cap_q ? wstrb_q : axi_lite_req_i.w.strb;
    assign ar_addr = axi_lite_req_i.ar.addr;
    assign unused_addr_bits = ^{wa[1:0], ar_addr[1:0]};

    // STATUS snapshot from current FIFO state, i.e. before this cycle's updates
    always_comb begin
        status_c = '0;
        status_c[STATUS_H2S_EMPTY] = h2s_empty;
        status_c[STATUS_H2S_FULL]  = h2s_full;
        status_c[STATUS_S2H_EMPTY] = s2h_empty;
        status_c[STATUS_S2H_FULL]  = s2h_full;
        status_c[STATUS_H2S_CNT +: STATUS_CNT_W] =
            h2s_full ? STATUS_CNT_W'(DEPTH) : STATUS_CNT_W'(h2s_usage);
        status_c[STATUS_S2H_CNT +: STATUS_CNT_W] =
            s2h_full ? STATUS_CNT_W'(DEPTH) : STATUS_CNT_W'(s2h_usage);
    end

    // Write channel FSM and register side effects
    always_comb begin
        w_state_d = w_state_q;
        aw_cap_d  = aw_cap_q;
        w_cap_d   = w_cap_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        scratch_d = scratch_q;
        h2s_push  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_cap_d = 1'b1;
                    waddr_d  = axi_lite_req_i.aw.addr;
                end
                if (w_hs) begin
                    w_cap_d = 1'b1;
                    wdata_d = axi_lite_req_i.w.data;
                    wstrb_d = axi_lite_req_i.w.strb;
                end
                if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
                    aw_cap_d  = 1'b0;
                    w_cap_d   = 1'b0;
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    if (wa[31:4] != '0) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        case (wa[3:2])
                            REG_H2S_DATA: begin
                                if (ws == 4'hF && (!h2s_full || h2s_pop)) begin
                                    h2s_push = 1'b1;
                                end else begin
                                    bresp_d = RESP_SLVERR;
                                end
                            end
                            REG_SCRATCH: begin
                                for (int unsigned i = 0; i < 4; i++) begin
                                    if (ws[i]) scratch_d[8*i +: 8] = wd[8*i +: 8];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            W_RESP: begin
                if (axi_lite_req_i.b_ready) w_state_d = W_IDLE;
            end
        endcase
    end

    // Read channel FSM; an S2H pop happens only at the AR handshake
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        s2h_pop   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    if (ar_addr[31:4] != '0) begin
                        rresp_d = RESP_SLVERR;
                    end else begin
                        case (ar_addr[3:2])
                            REG_S2H_DATA: begin
                                if (s2h_empty) begin
                                    rresp_d = RESP_SLVERR;
                                end else begin
                                    rdata_d = s2h_head;
                                    s2h_pop = 1'b1;
                                end
                            end
                            REG_STATUS:  rdata_d = status_c;
                            REG_SCRATCH: rdata_d = scratch_q;
                            default: ;
                        endcase
                    end
                end
            end
            R_RESP: begin
                if (axi_lite_req_i.r_ready) r_state_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        axi_lite_rsp_o          = '0;
        axi_lite_rsp_o.aw_ready = aw_ready_c;
        axi_lite_rsp_o.w_ready  = w_ready_c;
        axi_lite_rsp_o.b.resp   = bresp_q;
        axi_lite_rsp_o.b_valid  = (w_state_q == W_RESP);
        axi_lite_rsp_o.ar_ready = ar_ready_c;
        axi_lite_rsp_o.r.data   = rdata_q;
        axi_lite_rsp_o.r.resp   = rresp_q;
        axi_lite_rsp_o.r_valid  = (r_state_q == R_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            scratch_q <= '0;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            scratch_q <= scratch_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_occamy_spi_mailbox.sv
// Directed bench for occamy_spi_mailbox: a queue-based mailbox model is stepped
// alongside the DUT and compared every cycle, plus literal expectations.
module tb_occamy_spi_mailbox;
    import occamy_spi_mailbox_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    mb_req_t     req;
    mb_rsp_t     rsp;
    logic [31:0] h2s_data, s2h_data;
    logic        h2s_valid, h2s_ready, s2h_valid, s2h_ready;

    always #5 clk = ~clk;

    occamy_spi_mailbox #(
        .axi_lite_req_t (mb_req_t),
        .axi_lite_resp_t(mb_rsp_t),
        .DEPTH          (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .axi_lite_req_i(req),
        .axi_lite_rsp_o(rsp),
        .h2s_data_o    (h2s_data),
        .h2s_valid_o   (h2s_valid),
        .h2s_ready_i   (h2s_ready),
        .s2h_data_i    (s2h_data),
        .s2h_valid_i   (s2h_valid),
        .s2h_ready_o   (s2h_ready)
    );

    int checks = 0;
    int errors = 0;

    // Mailbox model
    logic [31:0] m_h2s[$];
    logic [31:0] m_s2h[$];
    logic [31:0] m_scratch;
    bit          exp_b_valid, exp_r_valid, aw_done, w_done;
    logic [1:0]  exp_bresp, exp_rresp;
    logic [31:0] exp_rdata;
    logic [31:0] wa, wd;
    logic [3:0]  ws;

    logic [1:0]  last_bresp, last_rresp;
    logic [31:0] last_rdata;
    int          b_seen;
    logic [31:0] popped[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {12'd0, 4'(m_s2h.size()), 4'd0, 4'(m_h2s.size()), 4'd0,
                m_s2h.size() == DEPTH, m_s2h.size() == 0,
                m_h2s.size() == DEPTH, m_h2s.size() == 0};
    endfunction

    // One clock: compare at negedge, advance the model over the coming posedge
    task automatic step();
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, pop_h2s, push_h2s, pop_s2h, push_s2h;
        aw_hs = 0; w_hs = 0; ar_hs = 0; push_h2s = 0; pop_s2h = 0;
        @(negedge clk);
        check32("h2s_valid", 32'(h2s_valid), 32'(m_h2s.size() != 0));
        if (m_h2s.size() != 0) check32("h2s_data", h2s_data, m_h2s[0]);
        check32("s2h_ready", 32'(s2h_ready), 32'(m_s2h.size() < DEPTH));
        check32("aw_ready", 32'(rsp.aw_ready), 32'(!exp_b_valid && !aw_done));
        check32("w_ready", 32'(rsp.w_ready), 32'(!exp_b_valid && !w_done));
        check32("ar_ready", 32'(rsp.ar_ready), 32'(!exp_r_valid));
        check32("b_valid", 32'(rsp.b_valid), 32'(exp_b_valid));
        if (exp_b_valid) check32("b_resp", 32'(rsp.b.resp), 32'(exp_bresp));
        check32("r_valid", 32'(rsp.r_valid), 32'(exp_r_valid));
        if (exp_r_valid) begin
            check32("r_data", rsp.r.data, exp_rdata);
            check32("r_resp", 32'(rsp.r.resp), 32'(exp_rresp));
        end
        if (rst_n) begin
            aw_hs    = req.aw_valid && !exp_b_valid && !aw_done;
            w_hs     = req.w_valid && !exp_b_valid && !w_done;
            ar_hs    = req.ar_valid && !exp_r_valid;
            b_hs     = exp_b_valid && req.b_ready;
            r_hs     = exp_r_valid && req.r_ready;
            pop_h2s  = (m_h2s.size() != 0) && h2s_ready;
            push_s2h = s2h_valid && (m_s2h.size() < DEPTH);
            if (pop_h2s) popped.push_back(h2s_data);
            if (b_hs) begin
                b_seen++;
                last_bresp  = rsp.b.resp;
                exp_b_valid = 0;
            end
            if (r_hs) begin
                last_rdata  = rsp.r.data;
                last_rresp  = rsp.r.resp;
                exp_r_valid = 0;
            end
            if (aw_hs) begin aw_done = 1; wa = req.aw.addr; end
            if (w_hs) begin w_done = 1; wd = req.w.data; ws = req.w.strb; end
            if (aw_done && w_done) begin
                aw_done = 0; w_done = 0; exp_b_valid = 1; exp_bresp = RESP_OKAY;
                if (wa[31:4] != 0) exp_bresp = RESP_SLVERR;
                else if (wa[3:2] == 2'd0) begin
                    if (ws == 4'hF && (m_h2s.size() < DEPTH || pop_h2s)) push_h2s = 1;
                    else exp_bresp = RESP_SLVERR;
                end else if (wa[3:2] == 2'd3) begin
                    for (int i = 0; i < 4; i++) if (ws[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
                end
            end
            if (ar_hs) begin
                exp_r_valid = 1; exp_rdata = 0; exp_rresp = RESP_OKAY;
                if (req.ar.addr[31:4] != 0) exp_rresp = RESP_SLVERR;
                else case (req.ar.addr[3:2])
                    2'd1: if (m_s2h.size() == 0) exp_rresp = RESP_SLVERR;
                          else begin exp_rdata = m_s2h[0]; pop_s2h = 1; end
                    2'd2: exp_rdata = m_status();
                    2'd3: exp_rdata = m_scratch;
                    default: ;
                endcase
            end
            if (pop_h2s) void'(m_h2s.pop_front());
            if (push_h2s) m_h2s.push_back(wd);
            if (pop_s2h) void'(m_s2h.pop_front());
            if (push_s2h) m_s2h.push_back(s2h_data);
        end
        @(posedge clk);
        #1;
        if (aw_hs) req.aw_valid = 0;
        if (w_hs) req.w_valid = 0;
        if (ar_hs) req.ar_valid = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!req.aw_valid && !req.w_valid && !req.ar_valid && !exp_b_valid && !exp_r_valid)
                return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL timeout: AXI transaction did not complete within 50 cycles");
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int w_lead, output logic [1:0] resp);
        req.w.data = data; req.w.strb = strb; req.w_valid = 1;
        repeat (w_lead) step();
        req.aw.addr = addr; req.aw_valid = 1;
        wait_idle();
        resp = last_bresp;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        req.ar.addr = addr; req.ar_valid = 1;
        wait_idle();
        data = last_rdata;
        resp = last_rresp;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 0;
        req = '0; req.b_ready = 1; req.r_ready = 1;
        s2h_valid = 0;
        m_h2s.delete(); m_s2h.delete(); m_scratch = 0;
        exp_b_valid = 0; exp_r_valid = 0; aw_done = 0; w_done = 0;
        repeat (2) step();
        check32("rst_aw_ready", 32'(rsp.aw_ready), 32'd1);
        check32("rst_ar_ready", 32'(rsp.ar_ready), 32'd1);
        check32("rst_b_valid", 32'(rsp.b_valid), 32'd0);
        check32("rst_s2h_ready", 32'(s2h_ready), 32'd1);
        rst_n = 1;
        step();
    endtask

    initial begin
        logic [1:0]  resp;
        logic [1:0]  resps[9];
        logic [31:0] data;
        rst_n = 0; req = '0; h2s_ready = 0; s2h_valid = 0; s2h_data = 0;
        last_bresp = 0; last_rresp = 0; last_rdata = 0; b_seen = 0;
        do_reset();
        check32("reset_h2s_valid", 32'(h2s_valid), 32'd0);

        // Single H2S push with consumer stalled
        wr(32'h0, 32'hDEADBEEF, 4'hF, 0, resp);
        check32("h2s_push_resp", 32'(resp), 32'(RESP_OKAY));
        check32("h2s_valid_after_push", 32'(h2s_valid), 32'd1);
        check32("h2s_data_after_push", h2s_data, 32'hDEADBEEF);
        rd(32'h8, data, resp);
        check32("status_one_word", data, 32'h00000104);

        // Fill H2S past DEPTH, then push into full while draining
        h2s_ready = 1; step(); h2s_ready = 0;
        for (int i = 0; i < 9; i++) wr(32'h0, 32'h1000 + 32'(i), 4'hF, 0, resps[i]);
        check32("push8_resp", 32'(resps[7]), 32'(RESP_OKAY));
        check32("push9_resp", 32'(resps[8]), 32'(RESP_SLVERR));
        rd(32'h8, data, resp);
        check32("status_h2s_full", data, 32'h00000806);
        h2s_ready = 1;
        wr(32'h0, 32'hCAFE0001, 4'hF, 0, resp);
        check32("push_full_with_pop", 32'(resp), 32'(RESP_OKAY));
        repeat (12) step();
        h2s_ready = 0;
        check32("drain_count", 32'(popped.size()), 32'd10);
        check32("drain_first", popped[1], 32'h00001000);
        check32("drain_eighth", popped[8], 32'h00001007);
        check32("drain_last", popped[9], 32'hCAFE0001);

        // S2H empty read, single word, status coincident with push
        rd(32'h4, data, resp);
        check32("s2h_empty_data", data, 32'h0);
        check32("s2h_empty_resp", 32'(resp), 32'(RESP_SLVERR));
        s2h_data = 32'h12345678; s2h_valid = 1; step(); s2h_valid = 0;
        rd(32'h4, data, resp);
        check32("s2h_pop_data", data, 32'h12345678);
        check32("s2h_pop_resp", 32'(resp), 32'(RESP_OKAY));
        rd(32'h8, data, resp);
        check32("status_s2h_empty_bit", 32'(data[2]), 32'd1);
        s2h_data = 32'hA0; s2h_valid = 1; req.ar.addr = 32'h8; req.ar_valid = 1;
        step(); s2h_valid = 0; wait_idle();
        check32("status_pre_update", last_rdata, 32'h00000005);
        for (int i = 0; i < 9; i++) begin s2h_data = 32'hB0 + 32'(i); s2h_valid = 1; step(); end
        s2h_valid = 0;
        rd(32'h8, data, resp);
        check32("status_s2h_full", data, 32'h00080009);
        rd(32'h4, data, resp);
        check32("s2h_head_after_fill", data, 32'hA0);
        for (int i = 0; i < 7; i++) rd(32'h4, data, resp);
        check32("s2h_last", data, 32'hB6);
        rd(32'h8, data, resp);
        check32("status_s2h_drained", data, 32'h00000005);

        // Channel ordering: W ahead of AW, then both together
        b_seen = 0; wr(32'hC, 32'h01020304, 4'hF, 3, resp);
        check32("w_first_b_count", 32'(b_seen), 32'd1);
        b_seen = 0; wr(32'hC, 32'h55667788, 4'hF, 0, resp);
        check32("aw_w_together_b_count", 32'(b_seen), 32'd1);

        // SCRATCH byte strobes, decode errors, ignored accesses
        wr(32'hC, 32'hAABBCCDD, 4'hF, 0, resp);
        wr(32'hC, 32'h11223344, 4'h5, 0, resp);
        rd(32'hC, data, resp);
        check32("scratch_strb", data, 32'hAA22CC44);
        wr(32'h10, 32'h1, 4'hF, 0, resp);
        check32("wr_0x10_resp", 32'(resp), 32'(RESP_SLVERR));
        rd(32'h10, data, resp);
        check32("rd_0x10_resp", 32'(resp), 32'(RESP_SLVERR));
        rd(32'hC, data, resp);
        check32("scratch_untouched", data, 32'hAA22CC44);
        wr(32'h0, 32'h77, 4'h7, 0, resp);
        check32("h2s_partial_strb", 32'(resp), 32'(RESP_SLVERR));
        wr(32'h4, 32'h1, 4'hF, 0, resp);
        check32("wr_s2h_ignored", 32'(resp), 32'(RESP_OKAY));
        wr(32'h8, 32'hFFFFFFFF, 4'hF, 0, resp);
        check32("wr_status_ignored", 32'(resp), 32'(RESP_OKAY));
        rd(32'h0, data, resp);
        check32("rd_h2s_data", data, 32'h0);

        // Reset while holding a write response with three words queued
        wr(32'h0, 32'h31, 4'hF, 0, resp);
        wr(32'h0, 32'h32, 4'hF, 0, resp);
        req.b_ready = 0;
        req.w.data = 32'h33; req.w.strb = 4'hF; req.w_valid = 1;
        req.aw.addr = 32'h0; req.aw_valid = 1;
        step(); step();
        check32("held_b_valid", 32'(rsp.b_valid), 32'd1);
        do_reset();
        check32("post_reset_b_valid", 32'(rsp.b_valid), 32'd0);
        rd(32'h8, data, resp);
        check32("post_reset_status", data, 32'h00000005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/occamy_spi_mailbox.md
OCCAMY_SPI_MAILBOX -- requirements
Module: occamy_spi_mailbox

Interface
REQ-001 SHALL have parameter axi_lite_req_t, default logic, meaning the AXI-lite request struct driven by the upstream SPI slave.
REQ-002 SHALL have parameter axi_lite_resp_t, default logic, meaning the matching AXI-lite response struct.
REQ-003 SHALL have parameter DEPTH, default 8, meaning entries per FIFO; power of two, at least 2.
REQ-004 SHALL have port clk_i, input, width 1: the single clock for the whole block.
REQ-005 SHALL have port rst_ni, input, width 1: reset, asynchronous, active-low.
REQ-006 SHALL have port axi_lite_req_i, input, width axi_lite_req_t: AXI-lite requests from occamy_spi_slave; data width 32.
REQ-007 SHALL have port axi_lite_rsp_o, output, width axi_lite_resp_t: AXI-lite responses.
REQ-008 SHALL have ports h2s_data_o (output, 32), h2s_valid_o (output, 1) and h2s_ready_i (input, 1): host-to-SoC stream.
REQ-009 SHALL have ports s2h_data_i (input, 32), s2h_valid_i (input, 1) and s2h_ready_o (output, 1): SoC-to-host stream.

Function
REQ-010 SHALL decode addr[3:2] as four registers: 0x0 H2S_DATA, 0x4 S2H_DATA, 0x8 STATUS, 0xC SCRATCH.
- Any set bit in addr above bit 3: SLVERR, no side effect.
REQ-011 H2S_DATA write SHALL push w.data into the H2S FIFO.
- FIFO full, or strb not 4'hF: SLVERR, data dropped.
- A read of H2S_DATA returns 0 with OKAY.
REQ-012 S2H_DATA read SHALL pop the S2H FIFO and return the head with OKAY.
- FIFO empty: r.data 0, SLVERR.
- A write to S2H_DATA is ignored with OKAY.
REQ-013 STATUS SHALL be read-only (writes ignored, OKAY). Fields:
- bit0 h2s_empty, bit1 h2s_full, bit2 s2h_empty, bit3 s2h_full.
- [11:8] h2s count, [19:16] s2h count.
- All other bits 0.
REQ-014 SCRATCH SHALL be read/write, honouring strb per byte.
REQ-015 Write channel SHALL use an FSM with states W_IDLE, W_RESP:
- In W_IDLE, aw_ready and w_ready are high for each channel not yet captured; AW and W may arrive in either order or together.
- Once both are captured, the access executes and the FSM enters W_RESP in the next cycle with b_valid high.
- b_valid holds, with b.resp stable, until b_ready; then back to W_IDLE.
REQ-016 Read channel SHALL use an FSM with states R_IDLE, R_RESP:
- ar_ready is high only in R_IDLE.
- r_valid rises in the cycle after the AR handshake and holds with r.data/r.resp stable until r_ready.
- A pop takes effect at the AR handshake, exactly once.
REQ-017 Read and write FSMs SHALL run independently and concurrently; a STATUS read coincident with a push or pop returns the pre-update value.
REQ-018 h2s_valid_o SHALL equal !h2s_empty and h2s_data_o SHALL be the H2S head; a pop occurs when h2s_valid_o and h2s_ready_i are both high.
REQ-019 s2h_ready_o SHALL equal !s2h_full; a push occurs when s2h_valid_i and s2h_ready_o are both high.
REQ-020 Same-cycle push and pop on one FIFO SHALL both succeed, leaving the count unchanged; a push to a full FIFO SHALL be allowed when a pop occurs in the same cycle.
REQ-021 Counts SHALL saturate at DEPTH (full) and 0 (empty); pointers wrap modulo DEPTH.
REQ-022 The block SHALL drive b.resp and r.resp as 2'b00 (OKAY) or 2'b10 (SLVERR) only.

Reset
REQ-023 While rst_ni is low, the block SHALL hold:
- both FSMs idle, both FIFOs empty, SCRATCH 0;
- b_valid, r_valid, h2s_valid_o low;
- aw_ready, w_ready, ar_ready high;
- s2h_ready_o high.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction with no response and no FIFO side effect after reset.

Structure
REQ-025 Register offsets, STATUS bit positions and the FSM state enums SHALL live in occamy_spi_mailbox_pkg.
REQ-026 Each FIFO SHALL be one instance of common_cells fifo_v3, DATA_WIDTH 32, DEPTH DEPTH, fall-through off.

Verification
REQ-027 Write H2S_DATA 0xDEADBEEF, strb 0xF, with h2s_ready_i low -> B OKAY; h2s_valid_o=1, h2s_data_o=0xDEADBEEF; STATUS reads 0x00000104.
REQ-028 Push 9 words with DEPTH=8 -> first 8 OKAY, 9th SLVERR; STATUS bit1=1, [11:8]=8; SoC drains 8 words in order.
REQ-029 Read S2H_DATA when empty -> r.data 0, SLVERR; SoC pushes 0x12345678, then read -> 0x12345678 OKAY, STATUS bit2=1.
REQ-030 W presented 3 cycles before AW, and separately AW and W together -> exactly one b_valid each, one cycle after the later handshake.
REQ-031 SCRATCH write 0xAABBCCDD strb 0xF, then write 0x11223344 strb 0x5, then read -> 0xAA22CC44; access at address 0x10 -> SLVERR.
REQ-032 Assert rst_ni low while in W_RESP with 3 words queued -> after release, b_valid low, STATUS 0x00000005.
